arith_cmd_issuer: RTL and testbench

Command-side controller for the signed arithmetic unit. It accepts operation requests over a valid/ready handshake, drives the unit's operand/enable/select inputs for exactly one cycle, and waits for the unit's registered result flag. It then captures result and carry into a held response register with its own valid/ready handshake. It screens divide-by-zero before issue, bounds the wait with a timeout, and counts successful completions.

---
 rtl/arith_cmd_issuer.sv | 109 ++++++++++
 tb/tb_arith_cmd_issuer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_cmd_issuer.sv
// Command-side controller for the signed arithmetic unit: issues one op, waits for the result flag, holds the response.
// Divide-by-zero is screened before issue; the wait is bounded by TIMEOUT_CYCLES; successful deliveries are counted.
module arith_cmd_issuer #(
   parameter int IN_DATA_WIDTH  = 16,
   parameter int OUT_DATA_WIDTH = 2*IN_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [IN_DATA_WIDTH-1:0]  cmd_a,
   input  logic [IN_DATA_WIDTH-1:0]  cmd_b,
   output logic [IN_DATA_WIDTH-1:0]  A,
   output logic [IN_DATA_WIDTH-1:0]  B,
   output logic                      Arith_Enable,
   output logic [1:0]                Arith_FUN_SEL,
   input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
   input  logic                      Arith_Flag,
   input  logic                      Carry_OUT,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [OUT_DATA_WIDTH-1:0] rsp_data,
   output logic                      rsp_carry,
   output logic                      rsp_err,
   output logic [15:0]               ops_count
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [1:0] OP_DIV = 2'b11;
   localparam logic [7:0] TMO    = 8'(TIMEOUT_CYCLES);

   logic [1:0] state;
   logic [7:0] timer;
   logic       div_zero;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= IDLE;
         timer         <= '0;
         div_zero      <= 1'b0;
         A             <= '0;
         B             <= '0;
         Arith_FUN_SEL <= '0;
         Arith_Enable  <= 1'b0;
         rsp_data      <= '0;
         rsp_carry     <= 1'b0;
         rsp_err       <= 1'b0;
         ops_count     <= '0;
      end else begin
         Arith_Enable <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  A             <= cmd_a;
                  B             <= cmd_b;
                  Arith_FUN_SEL <= cmd_op;
                  div_zero      <= (cmd_op == OP_DIV) && (cmd_b == '0);
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               timer <= '0;
               // A screened divide still spends this cycle here, so its error lands one cycle after accept
               if (div_zero) begin
                  rsp_data  <= '0;
                  rsp_carry <= 1'b0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  Arith_Enable <= 1'b1;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               if (Arith_Flag) begin
                  rsp_data  <= Arith_OUT;
                  rsp_carry <= Carry_OUT;
                  rsp_err   <= 1'b0;
                  state     <= RESP;
               end else if (timer == TMO) begin
                  rsp_data  <= '0;
                  rsp_carry <= 1'b0;
                  rsp_err   <= 1'b1;
                  state     <= RESP;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state <= IDLE;
                  if (!rsp_err) ops_count <= ops_count + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_arith_cmd_issuer.sv
// Bench for arith_cmd_issuer: stubbed arithmetic unit, directed vector table, random ops vs. a plain-arithmetic model.
module tb_arith_cmd_issuer;
   localparam int W  = 16;
   localparam int OW = 32;
   localparam int T  = 15;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [W-1:0]  cmd_a = '0;
   logic [W-1:0]  cmd_b = '0;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          Arith_Enable;
   logic [1:0]    Arith_FUN_SEL;
   logic [OW-1:0] Arith_OUT;
   logic          Arith_Flag;
   logic          Carry_OUT;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [OW-1:0] rsp_data;
   logic          rsp_carry;
   logic          rsp_err;
   logic [15:0]   ops_count;

   always #5 CLK = ~CLK;

   arith_cmd_issuer #(.IN_DATA_WIDTH(W), .OUT_DATA_WIDTH(OW), .TIMEOUT_CYCLES(T)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .A(A), .B(B), .Arith_Enable(Arith_Enable), .Arith_FUN_SEL(Arith_FUN_SEL),
      .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag), .Carry_OUT(Carry_OUT),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_carry(rsp_carry), .rsp_err(rsp_err), .ops_count(ops_count)
   );

   // Arithmetic unit stub: registered result one cycle after it samples enable
   logic          stub_dead   = 1'b0;
   logic          inject_flag = 1'b0;
   logic          unit_flag   = 1'b0;
   logic [OW-1:0] unit_out    = '0;
   logic          unit_carry  = 1'b0;

   assign Arith_Flag = unit_flag | inject_flag;
   assign Arith_OUT  = unit_out;
   assign Carry_OUT  = unit_carry;

   function automatic logic [32:0] unit_fn(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] ea, eb, r;
      logic [16:0] s17;
      logic        c;
      ea  = {{16{a[15]}}, a};
      eb  = {{16{b[15]}}, b};
      s17 = {1'b0, a} + {1'b0, b};
      c   = 1'b0;
      case (sel)
         2'b00: begin r = ea + eb; c = s17[16]; end
         2'b01: begin r = ea - eb; c = (a < b); end
         2'b10: r = ea * eb;
         default: r = (eb == 0) ? 32'sd0 : ea / eb;
      endcase
      return {c, r};
   endfunction

   always @(posedge CLK) begin
      if (stub_dead) begin
         unit_flag  <= 1'b0;
         unit_out   <= 32'hDEADBEEF;
         unit_carry <= 1'b1;
      end else if (Arith_Enable) begin
         {unit_carry, unit_out} <= unit_fn(Arith_FUN_SEL, A, B);
         unit_flag <= 1'b1;
      end else begin
         unit_flag <= 1'b0;
      end
   end

   int          total = 0;
   int          bad   = 0;
   logic [15:0] exp_count = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the response follows from the op's arithmetic meaning, not from any state sequence
   function automatic void ref_calc(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [31:0] d, output logic c, output logic e, output int lat);
      int sa, sb, ua, ub, r;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      e = 1'b0; c = 1'b0; lat = 3; r = 0;
      case (op)
         2'd0: begin r = sa + sb; c = (ua + ub) > 65535; end
         2'd1: begin r = sa - sb; c = ua < ub; end
         2'd2: r = sa * sb;
         default: begin
            if (b == 0) begin r = 0; e = 1'b1; lat = 1; end
            else r = sa / sb;
         end
      endcase
      d = r;
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int bp, input bit pre, input bit inj,
                         input logic [31:0] ed, input logic ec, input logic ee, input int elat);
      int k, en_at, en_n, exp_en;
      bit done;
      exp_en = (op == 2'b11 && b == 16'd0) ? 0 : 1;
      @(negedge CLK);
      check("cmd_ready_idle", cmd_ready, 1);
      rsp_ready = pre;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      @(posedge CLK);
      @(negedge CLK);
      cmd_valid = 1'b0;
      check("A_latched", A, a);
      check("B_latched", B, b);
      check("sel_latched", Arith_FUN_SEL, op);
      k = 0; en_at = -1; en_n = 0; done = 0;
      while (!done && k < 300) begin
         @(posedge CLK);
         k++;
         @(negedge CLK);
         if (Arith_Enable) begin
            en_n++;
            if (en_at < 0) en_at = k;
         end
         if (rsp_valid) done = 1;
      end
      check("rsp_latency", k, elat);
      if (!done) return;
      check("enable_pulses", en_n, exp_en);
      if (exp_en == 1) check("enable_time", en_at, 1);
      check("rsp_data", rsp_data, ed);
      check("rsp_carry", rsp_carry, ec);
      check("rsp_err", rsp_err, ee);
      check("cmd_ready_busy", cmd_ready, 0);
      if (!pre) begin
         for (int i = 0; i < bp; i++) begin
            if (inj && i == 0) inject_flag = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            inject_flag = 1'b0;
            check("bp_valid_held", rsp_valid, 1);
            check("bp_data_held", rsp_data, ed);
            check("bp_err_held", rsp_err, ee);
            check("bp_cmd_ready", cmd_ready, 0);
         end
         rsp_ready = 1'b1;
      end
      @(posedge CLK);
      @(negedge CLK);
      rsp_ready = 1'b0;
      if (!ee) exp_count++;
      check("rsp_released", rsp_valid, 0);
      check("cmd_ready_after", cmd_ready, 1);
      check("ops_count", ops_count, exp_count);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a, b;
      int          bp;
      logic [31:0] d;
      logic        c, e;
      int          lat;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ed;
      logic        ec, ee;
      int          elat, seen;
      logic [1:0]  rop;
      logic [15:0] ra, rb;

      tbl[0] = '{2'd0, 16'h7FFF, 16'h0001, 0, 32'h00008000, 1'b0, 1'b0, 3};
      tbl[1] = '{2'd0, 16'hFFFF, 16'hFFFF, 0, 32'hFFFFFFFE, 1'b1, 1'b0, 3};
      tbl[2] = '{2'd2, 16'hFFFD, 16'd5,    0, 32'hFFFFFFF1, 1'b0, 1'b0, 3};
      tbl[3] = '{2'd3, 16'd100,  16'hFFF9, 0, 32'hFFFFFFF2, 1'b0, 1'b0, 3};
      tbl[4] = '{2'd3, 16'd1234, 16'd0,    0, 32'h00000000, 1'b0, 1'b1, 1};
      tbl[5] = '{2'd1, 16'd5,    16'd7,    0, 32'hFFFFFFFE, 1'b1, 1'b0, 3};
      tbl[6] = '{2'd0, 16'd1,    16'd2,    5, 32'h00000003, 1'b0, 1'b0, 3};

      repeat (2) @(negedge CLK);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_enable", Arith_Enable, 0);
      check("rst_A", A, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_ops_count", ops_count, 0);
      RST = 1'b1;

      for (int i = 0; i < 7; i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].bp, 1'b0, 1'b0,
                tbl[i].d, tbl[i].c, tbl[i].e, tbl[i].lat);

      // rsp_ready already high when the response appears
      run_op(2'd2, 16'd7, 16'd6, 0, 1'b1, 1'b0, 32'd42, 1'b0, 1'b0, 3);

      // Dead unit: timeout, then a stray flag during RESP must not alter the response
      stub_dead = 1'b1;
      run_op(2'd0, 16'd9, 16'd9, 3, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, T + 2);
      stub_dead = 1'b0;

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = 16'($urandom);
         rb  = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
         ref_calc(rop, ra, rb, ed, ec, ee, elat);
         run_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, ed, ec, ee, elat);
      end

      // Asynchronous reset while waiting on a dead unit
      stub_dead = 1'b1;
      @(negedge CLK);
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 16'd1; cmd_b = 16'd2;
      @(posedge CLK);
      @(negedge CLK);
      cmd_valid = 1'b0;
      repeat (4) @(negedge CLK);
      check("pre_reset_count", ops_count, exp_count);
      #2 RST = 1'b0;
      #1;
      check("async_cmd_ready", cmd_ready, 1);
      check("async_rsp_valid", rsp_valid, 0);
      check("async_A", A, 0);
      check("async_B", B, 0);
      check("async_sel", Arith_FUN_SEL, 0);
      check("async_enable", Arith_Enable, 0);
      check("async_data", rsp_data, 0);
      check("async_carry", rsp_carry, 0);
      check("async_err", rsp_err, 0);
      check("async_ops_count", ops_count, 0);
      exp_count = '0;
      @(negedge CLK);
      RST = 1'b1;
      stub_dead = 1'b0;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge CLK);
         if (rsp_valid) seen++;
      end
      check("no_rsp_after_reset", seen, 0);
      check("idle_after_reset", cmd_ready, 1);

      run_op(2'd1, 16'd10, 16'd3, 1, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
